// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the RV32I ALU sequencing controller.
// Latency: n/a (types, constants only).
// Backpressure: n/a.
// Contents: FSM state enum, funct3 codes, one-hot enable bit positions.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam int EN_W    = 10;
    localparam int EN_ADD  = 0;
    localparam int EN_SUB  = 1;
    localparam int EN_SRA  = 2;
    localparam int EN_SLL  = 3;
    localparam int EN_SLT  = 4;
    localparam int EN_SLTU = 5;
    localparam int EN_XOR  = 6;
    localparam int EN_SRL  = 7;
    localparam int EN_OR   = 8;
    localparam int EN_AND  = 9;

    typedef logic [EN_W-1:0] alu_en_t;

endpackage

// File: rtl/alu_op_decode.sv
// Decodes funct3/funct7[5]/is_imm into the ALU's one-hot operation enable vector.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: funct3, funct7_5, is_imm in; en out (bit positions from alu_ctrl_pkg).
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_imm,
    output alu_en_t    en
);

    always_comb begin
        en = '0;
        unique case (funct3)
            // OP-IMM has no subtract: bit 30 there is part of the immediate.
            F3_ADD_SUB: en[(funct7_5 && !is_imm) ? EN_SUB : EN_ADD] = 1'b1;
            F3_SLL:     en[EN_SLL]  = 1'b1;
            F3_SLT:     en[EN_SLT]  = 1'b1;
            F3_SLTU:    en[EN_SLTU] = 1'b1;
            F3_XOR:     en[EN_XOR]  = 1'b1;
            // SRAI keeps bit 30 as the arithmetic selector, so is_imm is ignored.
            F3_SRL_SRA: en[funct7_5 ? EN_SRA : EN_SRL] = 1'b1;
            F3_OR:      en[EN_OR]   = 1'b1;
            F3_AND:     en[EN_AND]  = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin shares one combinational RV32I ALU between two requesters.
// Latency: accept at edge N, ALU enables in cycle N+1, response valid from cycle N+2.
// Backpressure: resp ready low holds the response and blocks all new grants.
// Ports: clk/rst; req0/req1 valid-ready request (funct3, funct7_5, is_imm, rs1, rs2);
//        resp0/resp1 valid-ready result; alu_*_en, alu_rs1/rs2 out, alu_rd_data in;
//        opcnt0/opcnt1 wrapping completed-response counters.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_funct3,
    input  logic              req0_funct7_5,
    input  logic              req0_is_imm,
    input  logic [DATA_W-1:0] req0_rs1,
    input  logic [DATA_W-1:0] req0_rs2,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_funct3,
    input  logic              req1_funct7_5,
    input  logic              req1_is_imm,
    input  logic [DATA_W-1:0] req1_rs1,
    input  logic [DATA_W-1:0] req1_rs2,

    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_data,

    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_data,

    output logic              alu_add_en,
    output logic              alu_sub_en,
    output logic              alu_sra_en,
    output logic              alu_sll_en,
    output logic              alu_slt_en,
    output logic              alu_sltu_en,
    output logic              alu_xor_en,
    output logic              alu_srl_en,
    output logic              alu_or_en,
    output logic              alu_and_en,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2,
    input  logic [DATA_W-1:0] alu_rd_data,

    output logic [CNT_W-1:0]  opcnt0,
    output logic [CNT_W-1:0]  opcnt1
);

    state_t              state;
    logic                grant;       // requester owning the in-flight op
    logic                last_grant;  // most recent winner, for tie-breaking
    alu_en_t             en_q;
    logic [DATA_W-1:0]   rs1_q;
    logic [DATA_W-1:0]   rs2_q;
    logic [DATA_W-1:0]   res_q;
    logic [CNT_W-1:0]    cnt0;
    logic [CNT_W-1:0]    cnt1;

    logic                win;
    logic                accept;
    logic                resp_done;
    logic                in_exec;
    logic                in_resp;
    alu_en_t             dec_en;
    alu_en_t             en_out;

    // On a tie the requester that did not win last time goes next;
    // otherwise whichever single requester is valid wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            win = ~last_grant;
        end else begin
            win = req1_valid;
        end
    end

    // Ready is gated by rst so nothing is offered while reset is held.
    assign req0_ready = (state == IDLE) && !rst && req0_valid && !win;
    assign req1_ready = (state == IDLE) && !rst && req1_valid &&  win;
    assign accept     = req0_ready || req1_ready;

    alu_op_decode u_dec (
        .funct3   (win ? req1_funct3   : req0_funct3),
        .funct7_5 (win ? req1_funct7_5 : req0_funct7_5),
        .is_imm   (win ? req1_is_imm   : req0_is_imm),
        .en       (dec_en)
    );

    assign in_exec = (state == EXEC);
    assign in_resp = (state == RESP);

    assign en_out      = in_exec ? en_q : '0;
    assign alu_add_en  = en_out[EN_ADD];
    assign alu_sub_en  = en_out[EN_SUB];
    assign alu_sra_en  = en_out[EN_SRA];
    assign alu_sll_en  = en_out[EN_SLL];
    assign alu_slt_en  = en_out[EN_SLT];
    assign alu_sltu_en = en_out[EN_SLTU];
    assign alu_xor_en  = en_out[EN_XOR];
    assign alu_srl_en  = en_out[EN_SRL];
    assign alu_or_en   = en_out[EN_OR];
    assign alu_and_en  = en_out[EN_AND];
    assign alu_rs1     = in_exec ? rs1_q : '0;
    assign alu_rs2     = in_exec ? rs2_q : '0;

    assign resp0_valid = in_resp && !grant;
    assign resp1_valid = in_resp &&  grant;
    assign resp0_data  = resp0_valid ? res_q : '0;
    assign resp1_data  = resp1_valid ? res_q : '0;
    assign resp_done   = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

    assign opcnt0 = cnt0;
    assign opcnt1 = cnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;   // requester 0 takes the first tie
            en_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            res_q      <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        grant      <= win;
                        last_grant <= win;
                        en_q       <= dec_en;
                        rs1_q      <= win ? req1_rs1 : req0_rs1;
                        rs2_q      <= win ? req1_rs2 : req0_rs2;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    res_q <= alu_rd_data;
                    state <= RESP;
                end
                RESP: begin
                    if (resp_done) begin
                        if (grant) begin
                            cnt1 <= cnt1 + CNT_W'(1);
                        end else begin
                            cnt0 <= cnt0 + CNT_W'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing and sharing controller for the 32-bit RV32I integer ALU. It arbitrates between two requesters (e.g. the issue stage and the address/branch helper) with round-robin fairness. It decodes each accepted request's funct3/funct7[5]/imm flag into the ALU's ten one-hot operation enables, drives the ALU operands for exactly one cycle, and captures the muxed result. It returns the result to the winning requester over a valid/ready response channel.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- CNT_W, 16, width of per-requester completed-op counters

Ports (N = 0, 1 for every `reqN_*`/`respN_*`/`opcntN` line):
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- reqN_valid  in  1  request present
- reqN_ready  out  1  request accepted when `valid && ready`
- reqN_funct3  in  3  RV32I funct3
- reqN_funct7_5  in  1  instruction bit 30
- reqN_is_imm  in  1  1 = OP-IMM form
- reqN_rs1, reqN_rs2  in  DATA_W  operands; rs2 is the immediate when is_imm
- respN_valid  out  1  result available
- respN_ready  in  1  result consumed when `valid && ready`
- respN_data  out  DATA_W  result
- alu_add_en, alu_sub_en, alu_sra_en, alu_sll_en, alu_slt_en, alu_sltu_en, alu_xor_en, alu_srl_en, alu_or_en, alu_and_en  out  1 each  one-hot ALU enables
- alu_rs1, alu_rs2  out  DATA_W  ALU operands
- alu_rd_data  in  DATA_W  ALU muxed result (combinational from enables/operands)
- opcntN  out  CNT_W  completed responses for requester N, wraps

## Operation
- FSM states:
  - IDLE: on any `reqN_valid`, grant → EXEC.
  - EXEC: always → RESP.
  - RESP: on `resp_valid && resp_ready` of the granted requester → IDLE.
- Arbitration:
  - Only one requester is granted at a time.
  - Single valid requester wins.
  - Both valid: the requester not equal to `last_grant` wins.
  - `last_grant` is updated on grant and resets to 1, so requester 0 wins the first tie.
- reqN_ready is 1 only in IDLE, only for the winner, and is combinational from valids and `last_grant`.
- Operand capture: rs1, rs2, and the decoded enable vector are registered on the accept edge.
- Decode by funct3:
  - 000: add, or sub when funct7_5=1 and is_imm=0.
  - 001: sll.
  - 010: slt.
  - 011: sltu.
  - 100: xor.
  - 101: srl, or sra when funct7_5=1, regardless of is_imm.
  - 110: or.
  - 111: and.
- Enables:
  - Exactly one enable is high during EXEC. All enables are 0 in every other state.
  - alu_rs1/alu_rs2 hold the captured operands during EXEC and are 0 otherwise.
- Result capture: alu_rd_data is registered at the end of EXEC into the response register.
- Response: respN_valid is asserted only for the granted requester and stays high with a stable respN_data until handshake.
- The non-granted requester's request stays pending; its valid/payload must be held by the requester.
- opcntN increments by 1 on each completed response handshake of requester N and wraps from 2^CNT_W−1 to 0.
- Async reset, including mid-operation:
  - While rst is high: all outputs 0, including reqN_ready; state = IDLE; all counters 0; `last_grant` = 1.
  - An in-flight operation is discarded with no response.

## Timing
- Accept at edge N; enables active in cycle N+1; respN_valid high from cycle N+2.
- Minimum occupancy is 3 cycles per op (IDLE, EXEC, RESP). Peak throughput is 1 op / 3 cycles.
- A response handshake at edge M returns the FSM to IDLE in cycle M+1, where a new grant may be issued.
- Back-pressure: respN_ready low holds RESP indefinitely; no new grants are issued.
- The ALU is purely combinational. alu_rd_data must settle within the EXEC cycle.

## Structure
- Package `alu_ctrl_pkg`:
  - state enum {IDLE, EXEC, RESP};
  - funct3 localparams (F3_ADD_SUB … F3_AND);
  - enable-vector bit-index constants for the 10 enables.
- Sub-module `alu_op_decode`: combinational decode of (funct3, funct7_5, is_imm) → 10-bit one-hot vector. Reused by the future immediate-path decoder.
- Top `alu_arbiter` contains the arbiter, FSM, operand/result registers, and counters.

## Test plan
- req0 only, funct3=000, f7_5=1, is_imm=0, rs1=10, rs2=3 → alu_sub_en is high for exactly 1 cycle; resp0_data=7 two cycles after accept; opcnt0=1.
- req0 and req1 both valid from reset:
  - req0 is granted first (xor, rs1=0xF0F0, rs2=0x0FF0 → 0xFF00).
  - Then req1 is granted (sltu, rs1=1, rs2=0xFFFFFFFF → 1).
  - Grants continue to alternate while both stay valid.
- funct3=101, f7_5=1, is_imm=1, rs1=0x80000000, rs2=4 → sra_en; result 0xF8000000.
- resp1_ready held low for 5 cycles with req0 valid → resp1_data stays stable; req0_ready stays 0; the req0 grant follows the handshake.
- rst asserted during EXEC → all outputs go to 0 immediately with no response. After release, req0 wins the next tie.
- opcnt0 preloaded by issuing 2^CNT_W ops (CNT_W=4 build, 16 ops) → wraps to 0.
